// File: rtl/pipeline_pkg.sv
// Shared arbiter types: FSM state encoding and a constant-width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pipeline_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Ceiling log2 for deriving index widths from a requester count.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipeline_rr_arbiter_select.sv
// Rotating find-first-set: first asserted req at or after ptr, wrapping mod NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; caller gates the grant with its own load enable.
module rr_priority_select
  import pipeline_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] idx,
  output logic                found
);

  logic [ID_WIDTH:0]   cand;
  logic [ID_WIDTH-1:0] cand_idx;

  // Walk ptr, ptr+1, ... with one extra bit so the wrap works for any NUM_REQ.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_WIDTH+1)'(k);
      if (cand >= (ID_WIDTH+1)'(NUM_REQ)) begin
        cand = cand - (ID_WIDTH+1)'(NUM_REQ);
      end
      cand_idx = cand[ID_WIDTH-1:0];
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
    if (found) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding one registered valid/ready stage, tagging beats with requester id.
// Latency: 1 cycle from u_valid&u_ready to d_valid; 1 beat/cycle with no gap between packets.
// Backpressure: while d_valid=1 and d_ready=0 the output register holds and every u_ready is 0.
module pipeline_rr_arbiter
  import pipeline_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int ID_WIDTH   = clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] u_data,
  input  logic [NUM_REQ-1:0]            u_valid,
  input  logic [NUM_REQ-1:0]            u_last,
  output logic [NUM_REQ-1:0]            u_ready,
  output logic [DATA_WIDTH-1:0]         d_data,
  output logic [ID_WIDTH-1:0]           d_id,
  output logic                          d_last,
  output logic                          d_valid,
  input  logic                          d_ready
);

  arb_state_t            state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   lock_id;
  logic [ID_WIDTH-1:0]   sel;
  logic [ID_WIDTH-1:0]   sel_next;
  logic [ID_WIDTH:0]     sel_inc;
  logic [ID_WIDTH-1:0]   ps_idx;
  logic [NUM_REQ-1:0]    ps_gnt;
  logic                  ps_found;
  logic                  grant_active;
  logic                  load_en;
  logic                  transfer;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ)
  ) u_select (
    .req   (u_valid),
    .ptr   (rr_ptr),
    .gnt   (ps_gnt),
    .idx   (ps_idx),
    .found (ps_found)
  );

  // Idle picks the next valid requester in rotation; a locked packet keeps its owner even through bubbles.
  always_comb begin
    sel          = ps_idx;
    grant_active = ps_found;
    if (state == ARB_LOCKED) begin
      sel          = lock_id;
      grant_active = 1'b1;
    end
  end

  assign load_en  = d_ready | ~d_valid;
  assign transfer = load_en & u_valid[sel] & grant_active;
  assign sel_last = u_last[sel];
  assign sel_data = u_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

  // Next rotation start is the requester after the one finishing its packet.
  assign sel_inc  = {1'b0, sel} + (ID_WIDTH+1)'(1);
  assign sel_next = (sel_inc == (ID_WIDTH+1)'(NUM_REQ)) ? '0 : sel_inc[ID_WIDTH-1:0];

  // Only the current owner sees ready, and only when the output stage can take a beat.
  always_comb begin
    u_ready = '0;
    if (load_en && grant_active) begin
      if (state == ARB_IDLE) begin
        u_ready = ps_gnt;
      end else begin
        u_ready[lock_id] = 1'b1;
      end
    end
  end

  // Grant FSM: lock on a non-last first beat, release and rotate on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else if (transfer) begin
      case (state)
        ARB_IDLE: begin
          if (sel_last) begin
            rr_ptr <= sel_next;
          end else begin
            state   <= ARB_LOCKED;
            lock_id <= sel;
          end
        end
        ARB_LOCKED: begin
          if (sel_last) begin
            state  <= ARB_IDLE;
            rr_ptr <= sel_next;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Output register: refill whenever empty or drained, keep payload during bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid <= 1'b0;
      d_data  <= '0;
      d_id    <= '0;
      d_last  <= 1'b0;
    end else if (load_en) begin
      d_valid <= transfer;
      if (transfer) begin
        d_data <= sel_data;
        d_id   <= sel;
        d_last <= sel_last;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// Bench for pipeline_rr_arbiter: directed scenarios plus randomized traffic against a cycle reference model.
// Latency: n/a.
// Backpressure: d_ready driven by the bench.
module tb_pipeline_rr_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] u_data;
  logic [N-1:0]   u_valid, u_last, u_ready;
  logic [W-1:0]   d_data;
  logic [1:0]     d_id;
  logic           d_last, d_valid, d_ready;

  logic [3*W-1:0] u_data3;
  logic [2:0]     u_valid3, u_last3, u_ready3;
  logic [W-1:0]   d_data3;
  logic [1:0]     d_id3;
  logic           d_last3, d_valid3, d_ready3;

  int checks   = 0;
  int failures = 0;

  // Requester sources: bit W is the last flag.
  logic [W:0]   srcq [N][$];
  logic [N-1:0] en;

  // Reference model: owner (-1 = none), rotation pointer and expected output register.
  int         m_owner;
  int         m_ptr;
  logic       m_dv, m_dl;
  logic [W-1:0] m_dd;
  logic [1:0] m_did;

  pipeline_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .u_data(u_data), .u_valid(u_valid), .u_last(u_last),
    .u_ready(u_ready), .d_data(d_data), .d_id(d_id), .d_last(d_last),
    .d_valid(d_valid), .d_ready(d_ready)
  );

  pipeline_rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(W)) dut3 (
    .clk(clk), .rst_n(rst_n), .u_data(u_data3), .u_valid(u_valid3), .u_last(u_last3),
    .u_ready(u_ready3), .d_data(d_data3), .d_id(d_id3), .d_last(d_last3),
    .d_valid(d_valid3), .d_ready(d_ready3)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_dv    = 1'b0;
    m_dd    = '0;
    m_did   = '0;
    m_dl    = 1'b0;
  endtask

  // Who may hand over a beat this cycle according to the arbitration rules.
  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int j;
    r = '0;
    if (!(d_ready || !m_dv)) return r;
    if (m_owner >= 0) begin
      r[m_owner] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (u_valid[j]) begin
        r[j] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic push_pkt(input int i, input int len, input logic [W-1:0] base);
    for (int b = 0; b < len; b++) srcq[i].push_back({(b == len - 1), base + W'(b)});
  endtask

  task automatic drive_inputs();
    logic [W:0] b;
    for (int i = 0; i < N; i++) begin
      if (en[i] && srcq[i].size() > 0) begin
        b = srcq[i][0];
        u_valid[i]       = 1'b1;
        u_data[i*W +: W] = b[W-1:0];
        u_last[i]        = b[W];
      end else begin
        u_valid[i]       = 1'b0;
        u_data[i*W +: W] = '0;
        u_last[i]        = 1'b0;
      end
    end
  endtask

  // Advance one clock: update the model, pop accepted beats, drive the next inputs.
  task automatic step();
    logic [N-1:0] acc, a;
    int j;
    acc = u_valid & u_ready;
    a   = model_ready() & u_valid;
    if (d_ready || !m_dv) begin
      if (a != '0) begin
        j = 0;
        for (int k = 0; k < N; k++) if (a[k]) j = k;
        m_dv  = 1'b1;
        m_dd  = u_data[j*W +: W];
        m_did = 2'(j);
        m_dl  = u_last[j];
        if (u_last[j]) begin
          m_owner = -1;
          m_ptr   = (j + 1) % N;
        end else begin
          m_owner = j;
        end
      end else begin
        m_dv = 1'b0;
      end
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) if (acc[i]) void'(srcq[i].pop_front());
    drive_inputs();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = '0; d_ready = 1'b1;
    u_data3 = '0; u_valid3 = '0; u_last3 = '0; d_ready3 = 1'b1;
    drive_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (d_valid !== 1'b0 || d_data !== '0 || d_id !== 2'd0 || d_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%h id=%0d l=%b exp all zero", d_valid, d_data, d_id, d_last);
    end
    checks++;
    if (u_ready !== 4'b0000 || d_valid3 !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got u_ready=%b d_valid3=%b exp 0000/0", u_ready, d_valid3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_rr_single();
    logic [W-1:0] exp_d;
    for (int i = 0; i < N; i++) begin
      push_pkt(i, 1, 32'h100 + W'(16 * i));
      push_pkt(i, 1, 32'h101 + W'(16 * i));
    end
    en = '1;
    drive_inputs();
    #1;
    checks++;
    if (d_valid !== 1'b0 || u_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rr_first got v=%b rdy=%b exp v=0 rdy=0001", d_valid, u_ready);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      exp_d = 32'h100 + W'(16 * (k % 4)) + W'(k / 4);
      checks++;
      if (d_valid !== 1'b1 || d_id !== 2'(k % 4) || d_data !== exp_d || d_last !== 1'b1) begin
        failures++;
        $display("FAIL rr_beat%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", k, d_valid, d_id, d_data, k % 4, exp_d);
      end
    end
    step();
    checks++;
    if (d_valid !== 1'b0) begin
      failures++;
      $display("FAIL rr_drain got v=%b exp 0", d_valid);
    end
  endtask

  task automatic test_lock();
    logic [1:0]   id_t [5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    logic [W-1:0] dd_t [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1};
    logic         ll_t [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]   rd_t [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
    push_pkt(1, 3, 32'hA0);
    push_pkt(2, 1, 32'hB0);
    push_pkt(2, 1, 32'hB1);
    drive_inputs();
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (u_ready !== rd_t[k]) begin
        failures++;
        $display("FAIL lock_ready%0d got %b exp %b", k, u_ready, rd_t[k]);
      end
      step();
      checks++;
      if (d_valid !== 1'b1 || d_id !== id_t[k] || d_data !== dd_t[k] || d_last !== ll_t[k]) begin
        failures++;
        $display("FAIL lock_beat%0d got v=%b id=%0d d=%h l=%b exp id=%0d d=%h l=%b",
                 k, d_valid, d_id, d_data, d_last, id_t[k], dd_t[k], ll_t[k]);
      end
    end
    step();
  endtask

  task automatic test_bubble();
    logic [3:0]   en_t [7] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
    logic         dv_t [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] dd_t [7] = '{32'hC0, 32'h0, 32'h0, 32'hC1, 32'hC2, 32'hD0, 32'h0};
    logic [1:0]   id_t [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
    logic [3:0]   rd_t [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0000, 4'b0000};
    push_pkt(0, 3, 32'hC0);
    push_pkt(3, 1, 32'hD0);
    en = 4'b0001;
    drive_inputs();
    #1;
    checks++;
    if (u_ready !== 4'b0001) begin
      failures++;
      $display("FAIL bubble_start got %b exp 0001", u_ready);
    end
    for (int s = 0; s < 7; s++) begin
      en = en_t[s];
      step();
      checks++;
      if (d_valid !== dv_t[s] || (dv_t[s] && (d_id !== id_t[s] || d_data !== dd_t[s]))) begin
        failures++;
        $display("FAIL bubble_out%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h",
                 s, d_valid, d_id, d_data, dv_t[s], id_t[s], dd_t[s]);
      end
      checks++;
      if (u_ready !== rd_t[s]) begin
        failures++;
        $display("FAIL bubble_ready%0d got %b exp %b", s, u_ready, rd_t[s]);
      end
    end
    en = '1;
  endtask

  task automatic test_backpressure();
    for (int b = 0; b < 3; b++) push_pkt(1, 1, 32'hF0 + W'(b));
    drive_inputs();
    #1;
    step();
    d_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (d_valid !== 1'b1 || d_id !== 2'd1 || d_data !== 32'hF0 || d_last !== 1'b1 || u_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b id=%0d d=%h rdy=%b exp v=1 id=1 d=f0 rdy=0000",
                 c, d_valid, d_id, d_data, u_ready);
      end
      step();
    end
    d_ready = 1'b1;
    #1;
    for (int b = 1; b < 3; b++) begin
      step();
      checks++;
      if (d_valid !== 1'b1 || d_id !== 2'd1 || d_data !== 32'hF0 + W'(b)) begin
        failures++;
        $display("FAIL bp_resume%0d got v=%b id=%0d d=%h exp d=%h", b, d_valid, d_id, d_data, 32'hF0 + W'(b));
      end
    end
    step();
    checks++;
    if (d_valid !== 1'b0 || srcq[1].size() != 0) begin
      failures++;
      $display("FAIL bp_drain got v=%b left=%0d exp 0/0", d_valid, srcq[1].size());
    end
  endtask

  task automatic test_wrap();
    logic [1:0]   id_t [4] = '{2'd2, 2'd3, 2'd0, 2'd3};
    logic [W-1:0] dd_t [4] = '{32'h60, 32'h80, 32'h70, 32'h81};
    push_pkt(2, 1, 32'h60);
    push_pkt(0, 1, 32'h70);
    push_pkt(3, 1, 32'h80);
    push_pkt(3, 1, 32'h81);
    drive_inputs();
    #1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (d_valid !== 1'b1 || d_id !== id_t[k] || d_data !== dd_t[k]) begin
        failures++;
        $display("FAIL wrap_beat%0d got v=%b id=%0d d=%h exp id=%0d d=%h", k, d_valid, d_id, d_data, id_t[k], dd_t[k]);
      end
    end
    step();
    u_data3  = {32'h32, 32'h31, 32'h30};
    u_last3  = 3'b111;
    u_valid3 = 3'b100;
    #1;
    checks++;
    if (u_ready3 !== 3'b100) begin
      failures++;
      $display("FAIL wrap3_first got %b exp 100", u_ready3);
    end
    @(negedge clk);
    u_valid3 = 3'b011;
    #1;
    checks++;
    if (d_valid3 !== 1'b1 || d_id3 !== 2'd2 || u_ready3 !== 3'b001) begin
      failures++;
      $display("FAIL wrap3_after2 got v=%b id=%0d rdy=%b exp v=1 id=2 rdy=001", d_valid3, d_id3, u_ready3);
    end
    @(negedge clk);
    u_valid3 = 3'b000;
    #1;
    checks++;
    if (d_valid3 !== 1'b1 || d_id3 !== 2'd0 || d_data3 !== 32'h30) begin
      failures++;
      $display("FAIL wrap3_beat got v=%b id=%0d d=%h exp v=1 id=0 d=30", d_valid3, d_id3, d_data3);
    end
  endtask

  task automatic test_reset_mid();
    push_pkt(1, 1, 32'hE0);
    push_pkt(1, 4, 32'h90);
    drive_inputs();
    #1;
    repeat (3) step();
    checks++;
    if (d_data !== 32'h91 || d_id !== 2'd1) begin
      failures++;
      $display("FAIL rstmid_pre got d=%h id=%0d exp d=91 id=1", d_data, d_id);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (d_valid !== 1'b0 || d_id !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_drop got v=%b id=%0d exp v=0 id=0", d_valid, d_id);
    end
    while (srcq[1].size() > 0) void'(srcq[1].pop_front());
    push_pkt(0, 1, 32'hC8);
    push_pkt(3, 1, 32'hD8);
    drive_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (u_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_grant got %b exp 0001", u_ready);
    end
    step();
    checks++;
    if (d_valid !== 1'b1 || d_id !== 2'd0 || d_data !== 32'hC8) begin
      failures++;
      $display("FAIL rstmid_beat got v=%b id=%0d d=%h exp v=1 id=0 d=c8", d_valid, d_id, d_data);
    end
    step();
    step();
  endtask

  task automatic test_random();
    bit drained;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() < 3 && $urandom_range(0, 3) == 0) push_pkt(i, $urandom_range(1, 4), $urandom);
      end
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 3) != 0);
      d_ready = ($urandom_range(0, 3) != 0);
      drive_inputs();
      #1;
      checks++;
      if (u_ready !== model_ready()) begin
        failures++;
        $display("FAIL rand_ready c%0d got %b exp %b", c, u_ready, model_ready());
      end
      checks++;
      if (d_valid !== m_dv || (m_dv && (d_id !== m_did || d_data !== m_dd || d_last !== m_dl))) begin
        failures++;
        $display("FAIL rand_out c%0d got v=%b id=%0d d=%h l=%b exp v=%b id=%0d d=%h l=%b",
                 c, d_valid, d_id, d_data, d_last, m_dv, m_did, m_dd, m_dl);
      end
      step();
    end
    en = '1;
    d_ready = 1'b1;
    drive_inputs();
    #1;
    drained = 1'b0;
    for (int c = 0; c < 300 && !drained; c++) begin
      drained = !d_valid;
      for (int i = 0; i < N; i++) if (srcq[i].size() != 0) drained = 1'b0;
      if (!drained) step();
    end
    checks++;
    if (!drained) begin
      failures++;
      $display("FAIL rand_drain got not drained exp all queues empty");
    end
  endtask

  initial begin
    test_reset();
    test_rr_single();
    test_lock();
    test_bubble();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_rr_arbiter.md
# pipeline_rr_arbiter

Round-robin arbiter that shares one valid/ready pipeline datapath among NUM_REQ upstream requesters. It selects one requester at a time, holds the grant for a whole packet (up to and including the beat with last asserted), and tags each beat with the requester index. It drives a single registered output stage into the shared pipeline; d_id travels with the data so downstream logic can route results back.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..16
- DATA_WIDTH, 32, payload width per beat
- ID_WIDTH, $clog2(NUM_REQ), width of d_id; derived, never overridden
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- u_data  in  NUM_REQ*DATA_WIDTH  requester payloads; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- u_valid  in  NUM_REQ  per-requester beat valid
- u_last  in  NUM_REQ  per-requester last beat of packet
- u_ready  out  NUM_REQ  per-requester accept; at most one bit high
- d_data  out  DATA_WIDTH  registered payload to pipeline
- d_id  out  ID_WIDTH  index of requester owning d_data
- d_last  out  1  registered last flag
- d_valid  out  1  registered valid
- d_ready  in  1  pipeline accept

## Operation
- Output register: load_en = d_ready | ~d_valid. On load_en, d_valid <= transfer; d_data/d_id/d_last <= selected requester's beat when transfer, otherwise hold their current values.
- transfer = load_en & u_valid[sel] & grant_active; u_ready[i] = load_en & grant_active & (sel == i).
- FSM, two states:
  - IDLE: sel = first i with u_valid[i] high, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ; grant_active = any u_valid. On transfer with u_last[sel]=0: go LOCKED, lock_id <= sel. On transfer with u_last[sel]=1: stay IDLE, rr_ptr <= (sel+1) mod NUM_REQ.
  - LOCKED: sel = lock_id; grant_active = 1. Other requesters see u_ready=0. On transfer with u_last[lock_id]=1: go IDLE, rr_ptr <= (lock_id+1) mod NUM_REQ. Otherwise stay LOCKED.
- Reset values: state IDLE, rr_ptr 0, lock_id 0, d_valid 0, d_data 0, d_id 0, d_last 0, u_ready all 0.
- rr_ptr wraps from NUM_REQ-1 to 0. Index arithmetic is done at ID_WIDTH+1 bits, then reduced mod NUM_REQ, so the wrap is correct for NUM_REQ values that are not a power of two.

## Timing
- Latency: 1 cycle from u_valid&u_ready to d_valid.
- Throughput: 1 beat/cycle while d_ready=1, including back-to-back packets from different requesters. There are no idle cycles between packets.
- u_ready is combinational from d_ready, d_valid, u_valid and FSM state. Requesters must not make u_valid depend on u_ready.
- Once u_valid is raised, the requester holds its u_data and u_last stable until it sees u_ready. The arbiter does not check this.
- Backpressure: with d_ready=0 and d_valid=1, the output register holds and all u_ready are 0.
- Locked requester drops u_valid mid-packet: the output sees bubbles and the grant is kept. No other requester is served until the last beat of the locked packet.
- Single-beat packet (u_last=1 on first beat): LOCKED is never entered and rr_ptr advances immediately.
- No requester valid in IDLE: d_valid falls after the current beat is accepted, and rr_ptr is unchanged.
- rst_n asserted mid-packet: the lock is dropped and the beat in the output register is discarded. After reset, arbitration restarts at requester 0.

## Structure
- Shared package pipeline_pkg holds the FSM state enum (ARB_IDLE, ARB_LOCKED) and a clog2 helper function. No other constants go in the package.
- Sub-module rr_priority_select: combinational find-first-set over NUM_REQ bits starting at rr_ptr. Outputs are a one-hot grant and its binary index.
- The top level holds the FSM, rr_ptr, lock_id and the output register.

## Test plan
- Reset, then all four requesters valid with single-beat packets (u_last=1) and d_ready=1 -> d_id sequence 0,1,2,3,0 on consecutive cycles, first d_valid one cycle after release.
- Requester 1 sends a 3-beat packet (data 0xA0,0xA1,0xA2) while requester 2 is continuously valid -> d_id=1 for three beats with d_last only on 0xA2, then d_id=2; u_ready[2]=0 throughout the lock.
- Requester 0 mid-packet drops u_valid for 2 cycles while requester 3 is valid -> two bubbles on d_valid, requester 3 not granted until requester 0's last beat.
- d_ready=0 for 5 cycles with d_valid=1 -> d_data/d_id/d_last stable, all u_ready=0; with d_ready back to 1, no beat is lost or duplicated.
- rr_ptr=3 with only requesters 0 and 3 valid -> grant 3, then 0 (wrap), then 3. With NUM_REQ=3, requester 2's grant is followed by requester 0.
- rst_n pulsed low during a locked 4-beat packet after beat 2 -> d_valid=0 immediately, state IDLE, next grant goes to the lowest-index valid requester.
